// File: rtl/reg_file_pkg.sv
// Types and default sizes shared by the register file modules and their
// readback helpers.
package reg_file_pkg;

  localparam int DEFAULT_NUM_REGS = 2;
  localparam int DEFAULT_DATA_W   = 8;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

endpackage

// File: rtl/reg_file_snapshot.sv
// Shadow copy of a whole register file. It captures every register in one
// cycle and reads one entry back through an indexed mux.
module reg_file_snapshot
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       capture,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic [ADDR_W-1:0]          rd_idx,
  output logic [DATA_W-1:0]          rd_data
);

  logic [DATA_W-1:0] shadow_r [NUM_REGS];
  logic [DATA_W-1:0] rd_data_s;

  // Shadow array: loads all registers at once when capture is high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_r[i] <= {DATA_W{1'b0}};
      end
    end else if (capture) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_r[i] <= regs_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  // Read mux. An index past the last register returns zero, which keeps
  // non-power-of-two sizes safe.
  always_comb begin
    rd_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_data_s = rd_data_s | ((rd_idx == ADDR_W'(i)) ? shadow_r[i] : {DATA_W{1'b0}});
    end
  end

  assign rd_data = rd_data_s;

endmodule

// File: rtl/reg_file_dumper.sv
// Snapshots a register file and streams it out one register per beat over
// valid/ready. Each beat carries its register address and a last flag.
module reg_file_dumper
  import reg_file_pkg::*;
#(
  parameter  int NUM_REGS = DEFAULT_NUM_REGS,
  parameter  int DATA_W   = DEFAULT_DATA_W,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  output logic                       done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e              state_r, state_s;
  logic [ADDR_W-1:0]   idx_r, idx_s;
  logic [DATA_W-1:0]   data_r, data_s;
  logic                busy_r, valid_r, done_r, done_s;
  logic                capture_s;
  logic [ADDR_W-1:0]   rd_idx_s;
  logic [DATA_W-1:0]   rd_data_s;

  // The data register is loaded one beat ahead, so the mux looks at idx+1.
  assign rd_idx_s = idx_r + ADDR_W'(1);

  reg_file_snapshot #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) u_snapshot (
    .clk       (clk),
    .reset_n   (reset_n),
    .capture   (capture_s),
    .regs_flat (regs_flat),
    .rd_idx    (rd_idx_s),
    .rd_data   (rd_data_s)
  );

  // Next-state, index and registered-output decode.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    data_s    = data_r;
    done_s    = 1'b0;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          capture_s = 1'b1;
          idx_s     = {ADDR_W{1'b0}};
          data_s    = regs_flat[DATA_W-1:0];
          state_s   = ST_STREAM;
        end else begin
          data_s = {DATA_W{1'b0}};
        end
      end
      ST_STREAM: begin
        if (out_ready) begin
          if (idx_r == LAST_IDX) begin
            state_s = ST_IDLE;
            idx_s   = {ADDR_W{1'b0}};
            data_s  = {DATA_W{1'b0}};
            done_s  = 1'b1;
          end else begin
            idx_s  = idx_r + ADDR_W'(1);
            data_s = rd_data_s;
          end
        end else begin
          data_s = data_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        idx_s   = {ADDR_W{1'b0}};
        data_s  = {DATA_W{1'b0}};
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      idx_r   <= {ADDR_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      data_r  <= data_s;
      busy_r  <= (state_s == ST_STREAM);
      valid_r <= (state_s == ST_STREAM);
      done_r  <= done_s;
    end
  end

  assign busy      = busy_r;
  assign out_valid = valid_r;
  assign out_data  = data_r;
  assign done      = done_r;
  assign out_addr  = valid_r ? idx_r : {ADDR_W{1'b0}};
  assign out_last  = valid_r & (idx_r == LAST_IDX);

endmodule

// File: tb/tb_reg_file_dumper.sv
// Bench for reg_file_dumper: a queue-based model checks a 2-register instance
// every cycle, and directed literal checks cover the 2- and 3-register cases.
module tb_reg_file_dumper;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        start2 = 1'b0, ready2 = 1'b0;
  logic [15:0] regs2 = 16'h0000;
  logic        busy2, valid2, last2, done2;
  logic [0:0]  addr2;
  logic [7:0]  data2;

  logic        start3 = 1'b0, ready3 = 1'b0;
  logic [23:0] regs3 = 24'h000000;
  logic        busy3, valid3, last3, done3;
  logic [1:0]  addr3;
  logic [7:0]  data3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file_dumper #(.NUM_REGS(2), .DATA_W(8)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .regs_flat(regs2),
    .busy(busy2), .out_valid(valid2), .out_ready(ready2), .out_addr(addr2),
    .out_data(data2), .out_last(last2), .done(done2)
  );

  reg_file_dumper #(.NUM_REGS(3), .DATA_W(8)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .regs_flat(regs3),
    .busy(busy3), .out_valid(valid3), .out_ready(ready3), .out_addr(addr3),
    .out_data(data3), .out_last(last3), .done(done3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the 2-register instance: the pending beats of a dump sit in a queue.
  typedef struct {
    int addr;
    int data;
    int last;
  } beat_t;

  beat_t q[$];
  bit    done_exp = 1'b0;
  beat_t popped;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      done_exp = 1'b0;
    end else begin
      done_exp = 1'b0;
      if (q.size() > 0) begin
        if (ready2) begin
          popped = q.pop_front();
          if (q.size() == 0) done_exp = 1'b1;
        end
      end else if (start2) begin
        for (int i = 0; i < 2; i++) begin
          q.push_back('{addr: i, data: int'(regs2[i*8 +: 8]), last: (i == 1) ? 1 : 0});
        end
      end
    end
  end

  int ev, ea, ed, el;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      ev = 1; ea = q[0].addr; ed = q[0].data; el = q[0].last;
    end else begin
      ev = 0; ea = 0; ed = 0; el = 0;
    end
    chk("m_valid", 32'(valid2), 32'(ev));
    chk("m_busy",  32'(busy2),  32'(ev));
    chk("m_addr",  32'(addr2),  32'(ea));
    chk("m_data",  32'(data2),  32'(ed));
    chk("m_last",  32'(last2),  32'(el));
    chk("m_done",  32'(done2),  32'(done_exp));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat2(input string name, input logic v, input logic a,
                       input logic [7:0] d, input logic l);
    chk({name, "_valid"}, 32'(valid2), 32'(v));
    chk({name, "_addr"},  32'(addr2),  32'(a));
    chk({name, "_data"},  32'(data2),  32'(d));
    chk({name, "_last"},  32'(last2),  32'(l));
  endtask

  task automatic beat3(input string name, input logic v, input logic [1:0] a,
                       input logic [7:0] d, input logic l);
    chk({name, "_valid"}, 32'(valid3), 32'(v));
    chk({name, "_addr"},  32'(addr3),  32'(a));
    chk({name, "_data"},  32'(data3),  32'(d));
    chk({name, "_last"},  32'(last3),  32'(l));
  endtask

  initial begin
    #12;
    beat2("rst", 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_busy", 32'(busy2), 32'h0);
    chk("rst_done", 32'(done2), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // Non-power-of-two instance.
    regs3 = 24'h030201; ready3 = 1'b1; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    beat3("n3_b0", 1'b1, 2'd0, 8'h01, 1'b0);
    tick();
    beat3("n3_b1", 1'b1, 2'd1, 8'h02, 1'b0);
    tick();
    beat3("n3_b2", 1'b1, 2'd2, 8'h03, 1'b1);
    tick();
    beat3("n3_end", 1'b0, 2'd0, 8'h00, 1'b0);
    chk("n3_done", 32'(done3), 32'h1);
    chk("n3_busy", 32'(busy3), 32'h0);
    tick();
    chk("n3_done_off", 32'(done3), 32'h0);

    // Basic dump.
    regs2 = 16'hB7A5; ready2 = 1'b1; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    beat2("t1_b0", 1'b1, 1'b0, 8'hA5, 1'b0);
    chk("t1_busy0", 32'(busy2), 32'h1);
    tick();
    beat2("t1_b1", 1'b1, 1'b1, 8'hB7, 1'b1);
    chk("t1_busy1", 32'(busy2), 32'h1);
    tick();
    chk("t1_done", 32'(done2), 32'h1);
    chk("t1_busy_end", 32'(busy2), 32'h0);
    tick();
    chk("t1_done_off", 32'(done2), 32'h0);

    // Backpressure on the first beat.
    ready2 = 1'b0; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      beat2("bp_hold", 1'b1, 1'b0, 8'hA5, 1'b0);
      if (i < 2) tick();
    end
    ready2 = 1'b1;
    tick();
    beat2("bp_b1", 1'b1, 1'b1, 8'hB7, 1'b1);
    tick();
    chk("bp_done", 32'(done2), 32'h1);

    // Snapshot coherence, start during STREAM, and restart in the done cycle.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    regs2 = 16'h1234;
    beat2("co_b0", 1'b1, 1'b0, 8'hA5, 1'b0);
    tick();
    beat2("co_b1", 1'b1, 1'b1, 8'hB7, 1'b1);
    tick();
    chk("co_done", 32'(done2), 32'h1);
    start2 = 1'b1;
    tick();
    beat2("b2b_b0", 1'b1, 1'b0, 8'h34, 1'b0);
    tick();
    beat2("b2b_b1", 1'b1, 1'b1, 8'h12, 1'b1);
    start2 = 1'b0;
    tick();
    chk("b2b_done", 32'(done2), 32'h1);
    chk("b2b_valid_end", 32'(valid2), 32'h0);
    tick();
    chk("ign_valid", 32'(valid2), 32'h0);

    // Reset while the first beat is stalled.
    ready2 = 1'b0; regs2 = 16'hB7A5; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("mr_valid_pre", 32'(valid2), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("mr_valid", 32'(valid2), 32'h0);
    chk("mr_busy",  32'(busy2),  32'h0);
    chk("mr_data",  32'(data2),  32'h0);
    tick();
    chk("mr_done_a", 32'(done2), 32'h0);
    reset_n = 1'b1;
    ready2 = 1'b1;
    tick();
    chk("mr_done_b", 32'(done2), 32'h0);
    tick();
    chk("mr_idle", 32'(valid2), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      start2 = ($urandom_range(0, 3) == 0);
      ready2 = ($urandom_range(0, 3) != 0);
      regs2  = 16'($urandom);
      tick();
    end
    start2 = 1'b0;
    ready2 = 1'b1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
